requant_tile_sched: RTL and testbench

Tile scheduler for the 16-lane requantization unit. Accepts one job (tile count, vectors per tile, quant mode) and issues the one-cycle config load. Gates the accumulator vector stream into the requantizer tile by tile, and answers the requantizer's per-channel parameter reload requests between tiles. Sits between the matmul accumulator output stage and the requantizer; the requantizer's ICB master port is not touched here.

---
 rtl/requant_tile_sched_if.sv | 36 +++
 rtl/requant_tile_sched.sv | 146 ++++++++++++++
 tb/tb_requant_tile_sched.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/requant_tile_sched_if.sv
// Handshake bundle between the tile scheduler, the accumulator output stage
// and the requantizer. The slave modport is the scheduler's view.
interface requant_tile_sched_if #(
    parameter int REG_WIDTH = 32
);
    logic                 start;
    logic                 cfg_per_channel;
    logic [REG_WIDTH-1:0] tile_count;
    logic [REG_WIDTH-1:0] vecs_per_tile;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [REG_WIDTH-1:0] tile_idx;
    logic                 acc_valid;
    logic                 acc_ready;
    logic                 rq_init_cfg;
    logic                 rq_in_valid;
    logic                 rq_out_valid;
    logic                 rq_load_quant_req;
    logic                 rq_load_quant_granted;
    logic                 rq_quant_params_valid;

    modport master (
        output start, cfg_per_channel, tile_count, vecs_per_tile,
        output acc_valid, rq_out_valid, rq_load_quant_req, rq_quant_params_valid,
        input  busy, done, err, tile_idx, acc_ready, rq_init_cfg, rq_in_valid,
        input  rq_load_quant_granted
    );

    modport slave (
        input  start, cfg_per_channel, tile_count, vecs_per_tile,
        input  acc_valid, rq_out_valid, rq_load_quant_req, rq_quant_params_valid,
        output busy, done, err, tile_idx, acc_ready, rq_init_cfg, rq_in_valid,
        output rq_load_quant_granted
    );
endinterface

// File: rtl/requant_tile_sched.sv
// Tile scheduler for the 16-lane requantizer: config load, per-tile input gating
// and parameter reload grants. REQUANT_SCHED_TIMEOUT_EN adds a parameter-wait watchdog.
module requant_tile_sched #(
    parameter int REG_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                 clk,
    input logic                 rstn,
    requant_tile_sched_if.slave bus
);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CFG     = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_STREAM  = 3'd3;
    localparam logic [2:0] ST_DRAIN   = 3'd4;
    localparam logic [2:0] ST_GAP     = 3'd5;
    localparam logic [2:0] ST_REGRANT = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    localparam logic [REG_WIDTH-1:0] ONE = REG_WIDTH'(1);

    logic [2:0]           state_q, state_d;
    logic                 pc_q, pc_d;
    logic [REG_WIDTH-1:0] tc_q, tc_d, vpt_q, vpt_d, tile_q, tile_d;
    logic [REG_WIDTH-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic                 hs, out_done, last_tile, timeout;

    assign bus.acc_ready             = (state_q == ST_STREAM) && (in_cnt_q < vpt_q);
    assign hs                        = bus.acc_valid & bus.acc_ready;
    assign bus.rq_in_valid           = hs;
    assign bus.busy                  = (state_q != ST_IDLE);
    assign bus.done                  = (state_q == ST_DONE);
    assign bus.rq_init_cfg           = (state_q == ST_CFG);
    assign bus.rq_load_quant_granted = (state_q == ST_REGRANT) && bus.rq_load_quant_req;
    assign bus.tile_idx              = tile_q;

    // An output strobe arriving in the exit cycle still belongs to this tile.
    assign out_done  = (out_cnt_q == vpt_q) ||
                       (bus.rq_out_valid && (out_cnt_q == vpt_q - ONE));
    assign last_tile = (tile_q == tc_q - ONE);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        tc_d      = tc_q;
        vpt_d     = vpt_q;
        tile_d    = tile_q;
        in_cnt_d  = hs ? in_cnt_q + ONE : in_cnt_q;
        out_cnt_d = out_cnt_q;
        if (state_q != ST_IDLE && bus.rq_out_valid && out_cnt_q != vpt_q)
            out_cnt_d = out_cnt_q + ONE;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.tile_count == '0 || bus.vecs_per_tile == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_CFG;
                        pc_d      = bus.cfg_per_channel;
                        tc_d      = bus.tile_count;
                        vpt_d     = bus.vecs_per_tile;
                        tile_d    = '0;
                        in_cnt_d  = '0;
                        out_cnt_d = '0;
                    end
                end
            end
            ST_CFG:  state_d = pc_q ? ST_WAIT : ST_STREAM;
            ST_WAIT: begin
                if (bus.rq_quant_params_valid) state_d = ST_STREAM;
                else if (timeout)              state_d = ST_DONE;
            end
            ST_STREAM: begin
                if (hs && in_cnt_q == vpt_q - ONE) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_done) begin
                    if (last_tile) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_GAP;
                        tile_d    = tile_q + ONE;
                        in_cnt_d  = '0;
                        out_cnt_d = '0;
                    end
                end
            end
            ST_GAP: state_d = pc_q ? ST_REGRANT : ST_STREAM;
            ST_REGRANT: begin
                if (bus.rq_load_quant_req) state_d = ST_WAIT;
                else if (timeout)          state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            pc_q      <= 1'b0;
            tc_q      <= '0;
            vpt_q     <= '0;
            tile_q    <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            tc_q      <= tc_d;
            vpt_q     <= vpt_d;
            tile_q    <= tile_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

`ifdef REQUANT_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            waiting, err_q, err_d;

    assign waiting = (state_q == ST_WAIT) || (state_q == ST_REGRANT);
    assign timeout = waiting && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign bus.err = err_q;

    always_comb begin
        wd_d  = (waiting && state_d == state_q) ? wd_q + WD_W'(1) : '0;
        err_d = timeout && (state_d == ST_DONE);
    end

    // err_q is only ever set on the edge into DONE, so it lines up with done.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end
`else
    assign timeout = 1'b0;
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_requant_tile_sched.sv
// Directed bench for requant_tile_sched with a 2-cycle requantizer model and a
// tile-index scoreboard filled at job start and drained on every rq_in_valid.
module tb_requant_tile_sched;
    localparam int RW = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    requant_tile_sched_if #(.REG_WIDTH(RW)) bus();

    requant_tile_sched #(.REG_WIDTH(RW), .TIMEOUT_CYCLES(TO)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_chk = 0, n_fail = 0, cyc = 0;
    int n_inv, n_rise, n_init, n_out, n_grant, n_busy, n_done, n_ready, n_err = 0;
    int cyc_init, cyc_ready, cyc_last_in, cyc_last_out, cyc_done, cyc_err, start_cyc;
    int tb_in, cur_vpt, acc_mode = 0;
    logic [RW-1:0] last_tile;
    logic prev_inv, prev_grant, pc_auto = 1'b0;
    logic [63:0] sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Requantizer latency model: rq_in_valid reappears 2 cycles later.
    logic p1, p2;
    always @(posedge clk or negedge rstn)
        if (!rstn) begin p1 <= 1'b0; p2 <= 1'b0; end
        else       begin p1 <= bus.rq_in_valid; p2 <= p1; end
    assign bus.rq_out_valid = p2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        n_inv = 0; n_rise = 0; n_init = 0; n_out = 0; n_grant = 0; n_busy = 0;
        n_done = 0; n_ready = 0; tb_in = 0; last_tile = '0;
        cyc_init = -1; cyc_ready = -1; cyc_last_in = -1; cyc_last_out = -1;
        cyc_done = -1; cyc_err = -1;
    endtask

    always @(negedge clk) if (rstn) begin
        logic [63:0] e;
        if (bus.tile_idx != last_tile) begin tb_in = 0; last_tile = bus.tile_idx; end
        if (bus.acc_valid && tb_in == cur_vpt) chk("ready_after_tile", bus.acc_ready, 0);
        if (bus.rq_in_valid) begin
            n_inv++; tb_in++; cyc_last_in = cyc;
            if (!prev_inv) n_rise++;
            e = (sb.size() != 0) ? sb.pop_front() : 'x;
            chk("sb_tile", bus.tile_idx, e);
        end
        prev_inv = bus.rq_in_valid;
        if (bus.acc_ready) begin
            n_ready++;
            if (cyc_ready < 0) cyc_ready = cyc;
            if (pc_auto) chk("ready_wo_params", bus.rq_quant_params_valid, 1);
        end
        if (bus.rq_init_cfg) begin n_init++; if (cyc_init < 0) cyc_init = cyc; end
        if (bus.rq_out_valid) begin n_out++; cyc_last_out = cyc; end
        if (bus.rq_load_quant_granted) begin
            n_grant++;
            chk("grant_req", bus.rq_load_quant_req, 1);
            chk("grant_1cyc", prev_grant, 0);
        end
        prev_grant = bus.rq_load_quant_granted;
        if (bus.busy) n_busy++;
        if (bus.done) begin n_done++; cyc_done = cyc; chk("done_busy", bus.busy, 1); end
        if (bus.err) begin n_err++; cyc_err = cyc; end
    end

    initial begin
        bus.acc_valid = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (acc_mode)
                1:       bus.acc_valid = 1'b1;
                2:       bus.acc_valid = 1'($urandom_range(0, 1));
                default: bus.acc_valid = 1'b0;
            endcase
        end
    end

    // Requantizer parameter side: asks for a reload once outputs flow, drops
    // params_valid for 3 cycles after each grant.
    initial begin
        int seen_g, seen_o, dly;
        seen_g = 0; seen_o = 0; dly = 0;
        bus.rq_load_quant_req = 1'b0;
        bus.rq_quant_params_valid = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!pc_auto) begin
                bus.rq_load_quant_req = 1'b0; bus.rq_quant_params_valid = 1'b0;
                dly = 0; seen_g = n_grant; seen_o = n_out;
            end else if (n_grant != seen_g) begin
                seen_g = n_grant; seen_o = n_out; dly = 3;
                bus.rq_load_quant_req = 1'b0; bus.rq_quant_params_valid = 1'b0;
            end else begin
                if (dly > 0) begin
                    dly--;
                    if (dly == 0) bus.rq_quant_params_valid = 1'b1;
                end else bus.rq_quant_params_valid = 1'b1;
                if (dly == 0 && n_out != seen_o) bus.rq_load_quant_req = 1'b1;
            end
        end
    end

    task automatic start_job(input logic pc, input int tc, input int vpt);
        clr_stats();
        cur_vpt = vpt;
        for (int t = 0; t < tc; t++)
            for (int v = 0; v < vpt; v++) sb.push_back(64'(t));
        bus.start = 1'b1; bus.cfg_per_channel = pc;
        bus.tile_count = RW'(tc); bus.vecs_per_tile = RW'(vpt);
        start_cyc = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k = 0;
        while (n_done == 0 && k < budget) begin @(posedge clk); #1; k++; end
        chk(tag, n_done, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_err"}, bus.err, 0);
        chk({tag, "_tile"}, bus.tile_idx, 0);
        chk({tag, "_ready"}, bus.acc_ready, 0);
        chk({tag, "_init"}, bus.rq_init_cfg, 0);
        chk({tag, "_inv"}, bus.rq_in_valid, 0);
        chk({tag, "_grant"}, bus.rq_load_quant_granted, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=hang required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int d0;
        bus.start = 1'b0; bus.cfg_per_channel = 1'b0;
        bus.tile_count = '0; bus.vecs_per_tile = '0;
        cur_vpt = 0; prev_inv = 1'b0; prev_grant = 1'b0;
        clr_stats();
        repeat (2) @(negedge clk);
        check_idle("reset");
        @(posedge clk); #1; rstn = 1'b1;
        @(posedge clk); #1;

        // Per-tensor, 2 tiles x 4 vectors, input always valid
        acc_mode = 1;
        start_job(1'b0, 2, 4);
        wait_done(100, "pt_done");
        chk("pt_init_cnt", n_init, 1);
        chk("pt_init_lat", cyc_init - start_cyc, 1);
        chk("pt_ready_lat", cyc_ready - start_cyc, 2);
        chk("pt_inv_cnt", n_inv, 8);
        chk("pt_tile_starts", n_rise, 2);
        chk("pt_done_lat", cyc_done - cyc_last_in, 3);
        chk("pt_done_after_out", cyc_done > cyc_last_out, 1);
        chk("pt_grants", n_grant, 0);
        chk("pt_sb_empty", sb.size(), 0);
        acc_mode = 0;

        // Per-channel, 3 tiles x 2 vectors
        acc_mode = 1;
        start_job(1'b1, 3, 2);
        repeat (5) begin @(posedge clk); #1; end
        chk("pc_no_ready_wo_params", n_ready, 0);
        pc_auto = 1'b1;
        wait_done(300, "pc_done");
        chk("pc_grants", n_grant, 2);
        chk("pc_inv_cnt", n_inv, 6);
        chk("pc_sb_empty", sb.size(), 0);
        pc_auto = 1'b0; acc_mode = 0;
        @(posedge clk); #1;

        // Empty job, then a start while busy that must be ignored
        start_job(1'b0, 0, 3);
        bus.start = 1'b1; bus.tile_count = RW'(1); bus.vecs_per_tile = RW'(1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        chk("zero_done_cnt", n_done, 1);
        chk("zero_done_lat", cyc_done - start_cyc, 1);
        chk("zero_busy_cycles", n_busy, 1);
        chk("zero_no_init", n_init, 0);
        chk("zero_busy_after", bus.busy, 0);

        // Random upstream stalls
        acc_mode = 2;
        start_job(1'b0, 2, 5);
        wait_done(300, "stall_done");
        chk("stall_inv_cnt", n_inv, 10);
        chk("stall_sb_empty", sb.size(), 0);
        acc_mode = 0;

        // Reset mid-STREAM after 3 vectors, then a clean job
        acc_mode = 1;
        start_job(1'b0, 2, 4);
        begin
            int k = 0;
            while (n_inv < 3 && k < 50) begin @(posedge clk); #1; k++; end
        end
        chk("rst_reached_3", n_inv, 3);
        d0 = n_done;
        rstn = 1'b0;
        @(negedge clk);
        check_idle("midrst");
        repeat (3) @(negedge clk);
        chk("midrst_no_done", n_done, d0);
        sb.delete();
        acc_mode = 0;
        @(posedge clk); #1; rstn = 1'b1;
        @(posedge clk); #1;
        acc_mode = 1;
        start_job(1'b0, 1, 3);
        wait_done(100, "post_rst_done");
        chk("post_rst_inv", n_inv, 3);
        chk("post_rst_init", n_init, 1);
        chk("post_rst_sb_empty", sb.size(), 0);
        acc_mode = 0;

`ifdef REQUANT_SCHED_TIMEOUT_EN
        // Parameters never arrive: watchdog ends the job with err
        start_job(1'b1, 2, 2);
        wait_done(100, "to_done");
        chk("to_done_lat", cyc_done - start_cyc, 18);
        chk("to_err_with_done", cyc_err, cyc_done);
        chk("to_no_ready", n_ready, 0);
        chk("to_idle_after", bus.busy, 0);
        sb.delete();
        chk("to_err_total", n_err, 1);
`else
        chk("err_never", n_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
